pimt_term: RTL and testbench
============================

# pimt_term

Parametrised fixed-point successor to the PIMT product terms: computes `out = K * a * (b * c)` in signed Q-format. Operand streams A and B/C arrive on independent valid/ready handshakes and are buffered in per-stream FIFOs, so they need not arrive in the same cycle. Matched pairs feed a two-stage multiply pipeline with output backpressure and overflow reporting. It sits between the phi/r front end and the PIMT accumulator.

## Interface

- `W`, 32: operand and result width in bits (signed two's complement).
- `FRAC`, 16: fractional bits; constraint 0 ≤ FRAC < W.
- `DEPTH`, 4: entries per input FIFO; power of two, ≥ 2.
- `K`, 32'hFFFE0000: signed W-bit constant in the same Q format (default −2.0).

Ports:

- `clk`  in  1: single clock; all logic rising-edge.
- `rst`  in  1: synchronous reset, active-high.
- `a_data`  in  W: stream A operand (phi_r).
- `a_vld`  in  1: stream A valid.
- `a_rdy`  out  1: stream A ready, equal to FIFO A not full.
- `bc_b`  in  W: stream B operand (rrmulpow).
- `bc_c`  in  W: stream C operand (alpha_i); sampled together with `bc_b`.
- `bc_vld`  in  1: B/C valid.
- `bc_rdy`  out  1: B/C ready, equal to FIFO BC not full.
- `out_data`  out  W: result.
- `out_ovf`  out  1: at least one product stage overflowed W bits for this result.
- `out_vld`  out  1: result valid.
- `out_rdy`  in  1: downstream ready.

## Operation

- Push: an operand is written to its FIFO on `x_vld & x_rdy`. A push to a full FIFO cannot occur because `rdy` is low. Push and pop in the same cycle leave the count unchanged.
- Pipeline enable: `en = !(out_vld & !out_rdy)`. A stall freezes stage 1 and the output registers.
- Pop: both FIFOs pop their head entries together when both are non-empty and `en` is high. A lone non-empty FIFO holds its data indefinitely.
- Stage 1 (registered on pop): each product below is formed at 2W bits, then arithmetic-shifted right by FRAC (truncation toward −∞), then reduced to W bits.
  - `p1 = (a*K) >>> FRAC`
  - `p2 = (b*c) >>> FRAC`
  - `v1` is set on pop and cleared when `en` is high and no pop occurs.
- Stage 2 (registered when `en`): `out_data = (p1*p2) >>> FRAC`, reduced to W bits.
  - `out_vld <= v1`.
  - `out_ovf` = OR of the p1, p2 and final overflow flags carried through the pipeline.
- Overflow: a reduction overflows when the shifted value lies outside [−2^(W−1), 2^(W−1)−1]. The value written on overflow depends on `PIMT_SAT_EN`.
- Ordering: results leave in strict FIFO-pair order. No reordering and no drops.

## Timing

- Reset values: `out_data` = 0, `out_ovf` = 0, `out_vld` = 0, `v1` = 0, both FIFO counts = 0. `a_rdy` and `bc_rdy` read 1 in the first cycle after reset.
- Reset mid-operation: all FIFO contents and in-flight results are discarded with no partial output. Inputs presented while `rst` is high are ignored.
- Latency: with the later operand accepted in cycle t and `out_rdy` high, `out_vld` is high in cycle t+3. The FIFO entry is visible in t+1, popped in t+1, `v1` is high in t+2.
- Throughput: one result per cycle while both FIFOs are non-empty and `out_rdy` is high.
- Backpressure: `out_data`, `out_ovf` and `out_vld` stay stable while `out_vld & !out_rdy`. No pop occurs during the stall. FIFOs keep accepting inputs until full.
- Full FIFO: at most DEPTH items are buffered on the leading stream. Its `rdy` drops in the cycle after the DEPTH-th accept and rises in the cycle after a pop.
- `rdy` is registered, derived from count only, and never depends combinationally on `vld` or `out_rdy`.

## Configuration

- `PIMT_SAT_EN` defined: an overflowing reduction clamps to `2^(W−1)−1` or `−2^(W−1)` according to the sign of the full-width value.
- `PIMT_SAT_EN` undefined: an overflowing reduction keeps the low W bits (two's-complement wrap).
- `out_ovf` is reported identically in both builds.

## Test plan

- Basic product: Q16.16, K = −2.0. Push a = 0x00018000 (1.5), b = 0x00020000 (2.0), c = 0x00004000 (0.25) in the same cycle t. Required: `out_data` = 0xFFFE8000 (−1.5), `out_ovf` = 0, `out_vld` high exactly in t+3.
- Skewed arrival: push A in cycle t and B/C in cycle t+5. Required: exactly one result, in cycle t+8, with the same value as the basic-product case.
- Fill and stall: push 6 A items with no B/C. Required: `a_rdy` low after the 4th accept. Then hold `out_rdy` = 0 and push 4 B/C items. Required: the first result is held stable, and after releasing `out_rdy` the 4 results emerge in order on consecutive cycles.
- Overflow: a = 0x7FFF0000, b = c = 0x00010000. Required with `PIMT_SAT_EN` defined: `out_data` = 0x80000000, `out_ovf` = 1. Required without it: `out_data` = 0x00020000, `out_ovf` = 1.
- Reset mid-flight: push 3 pairs, then assert `rst` for one cycle at t+2. Required: no `out_vld` afterwards, both `rdy` signals high, and a new pair yields a correct result 3 cycles after it is accepted.
- Random stress: 10k random operand pairs with random valid gaps and random `out_rdy`. Required: match a Q-format reference model bit-exactly, with no loss or duplication.

Source files
------------

// File: rtl/pimt_term.sv
// pimt_term: out = K * a * (b * c) in signed Q-format, two buffered operand streams, two-stage pipeline.
// Build option: define PIMT_SAT_EN to saturate overflowing reductions instead of wrapping.

module pimt_term_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] wr_data,
    input  logic         push,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic         rdy,
    output logic         nonempty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;

    always_comb begin
        count_next = count;
        if (push && !pop)
            count_next = count + CW'(1);
        else if (pop && !push)
            count_next = count - CW'(1);
    end

    // rdy is registered from the next count so it never sees vld combinationally
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            rdy    <= 1'b1;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            count <= count_next;
            rdy   <= (count_next != FULL);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push)
            mem[wr_ptr] <= wr_data;
    end

    assign head     = mem[rd_ptr];
    assign nonempty = (count != '0);
endmodule

module pimt_term #(
    parameter int           W     = 32,
    parameter int           FRAC  = 16,
    parameter int           DEPTH = 4,
    parameter logic [W-1:0] K     = 32'hFFFE0000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] a_data,
    input  logic         a_vld,
    output logic         a_rdy,
    input  logic [W-1:0] bc_b,
    input  logic [W-1:0] bc_c,
    input  logic         bc_vld,
    output logic         bc_rdy,
    output logic [W-1:0] out_data,
    output logic         out_ovf,
    output logic         out_vld,
    input  logic         out_rdy
);
    // Returns {overflow, W-bit result} of (x*y) >>> FRAC.
    function automatic logic [W:0] reduce(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [2*W-1:0]        prod;
        logic signed [2*W-1:0] shifted;
        logic                  ovf;
        prod    = {{W{x[W-1]}}, x} * {{W{y[W-1]}}, y};
        shifted = $signed(prod) >>> FRAC;
        // in range only if the bits above the W-bit sign are all copies of it
        ovf     = !((&shifted[2*W-1:W-1]) || !(|shifted[2*W-1:W-1]));
`ifdef PIMT_SAT_EN
        if (ovf)
            return {1'b1, shifted[2*W-1], {(W-1){!shifted[2*W-1]}}};
`endif
        return {ovf, shifted[W-1:0]};
    endfunction

    logic           push_a;
    logic           push_bc;
    logic           pop;
    logic           en;
    logic           a_ne;
    logic           bc_ne;
    logic [W-1:0]   a_head;
    logic [2*W-1:0] bc_head;
    logic [W:0]     r1;
    logic [W:0]     r2;
    logic [W:0]     r3;

    logic           v1;
    logic [W-1:0]   p1;
    logic [W-1:0]   p2;
    logic           s1_ovf;

    assign push_a  = a_vld & a_rdy;
    assign push_bc = bc_vld & bc_rdy;
    assign en      = !(out_vld && !out_rdy);
    assign pop     = a_ne & bc_ne & en;

    pimt_term_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo_a (
        .clk      (clk),
        .rst      (rst),
        .wr_data  (a_data),
        .push     (push_a),
        .pop      (pop),
        .head     (a_head),
        .rdy      (a_rdy),
        .nonempty (a_ne)
    );

    pimt_term_fifo #(.W(2*W), .DEPTH(DEPTH)) u_fifo_bc (
        .clk      (clk),
        .rst      (rst),
        .wr_data  ({bc_b, bc_c}),
        .push     (push_bc),
        .pop      (pop),
        .head     (bc_head),
        .rdy      (bc_rdy),
        .nonempty (bc_ne)
    );

    assign r1 = reduce(a_head, K);
    assign r2 = reduce(bc_head[2*W-1:W], bc_head[W-1:0]);
    assign r3 = reduce(p1, p2);

    always_ff @(posedge clk) begin
        if (rst) begin
            v1       <= 1'b0;
            p1       <= '0;
            p2       <= '0;
            s1_ovf   <= 1'b0;
            out_data <= '0;
            out_ovf  <= 1'b0;
            out_vld  <= 1'b0;
        end else if (en) begin
            if (pop) begin
                p1     <= r1[W-1:0];
                p2     <= r2[W-1:0];
                s1_ovf <= r1[W] | r2[W];
                v1     <= 1'b1;
            end else begin
                v1     <= 1'b0;
            end
            out_data <= r3[W-1:0];
            out_ovf  <= v1 & (s1_ovf | r3[W]);
            out_vld  <= v1;
        end
    end
endmodule

// File: tb/tb_pimt_term.sv
// Directed and random bench for pimt_term; results checked against a longint Q16.16 model via a scoreboard.
module tb_pimt_term;
    localparam int W     = 32;
    localparam int FRAC  = 16;
    localparam int DEPTH = 4;
    localparam logic [31:0] K_TB = 32'hFFFE0000;
    localparam int N = 10000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] a_data;
    logic        a_vld;
    logic        a_rdy;
    logic [31:0] bc_b;
    logic [31:0] bc_c;
    logic        bc_vld;
    logic        bc_rdy;
    logic [31:0] out_data;
    logic        out_ovf;
    logic        out_vld;
    logic        out_rdy;

    always #5 clk = ~clk;

    pimt_term #(.W(W), .FRAC(FRAC), .DEPTH(DEPTH), .K(K_TB)) dut (
        .clk      (clk),
        .rst      (rst),
        .a_data   (a_data),
        .a_vld    (a_vld),
        .a_rdy    (a_rdy),
        .bc_b     (bc_b),
        .bc_c     (bc_c),
        .bc_vld   (bc_vld),
        .bc_rdy   (bc_rdy),
        .out_data (out_data),
        .out_ovf  (out_ovf),
        .out_vld  (out_vld),
        .out_rdy  (out_rdy)
    );

    int errors = 0;
    int checks = 0;
    int n_exp  = 0;
    int n_out  = 0;
    logic [32:0] sb[$];
    logic [31:0] aq[$];
    logic [63:0] bcq[$];

    task automatic check(input string tag, input logic [32:0] obs, input logic [32:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [32:0] ref_red(input longint p);
        longint s;
        s = p >>> FRAC;
        if (s > 64'sd2147483647 || s < -(64'sd2147483648)) begin
`ifdef PIMT_SAT_EN
            return (s < 0) ? {1'b1, 32'h80000000} : {1'b1, 32'h7FFFFFFF};
`else
            return {1'b1, s[31:0]};
`endif
        end
        return {1'b0, s[31:0]};
    endfunction

    function automatic logic [32:0] ref_term(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        logic [32:0] r1;
        logic [32:0] r2;
        logic [32:0] r3;
        r1 = ref_red(longint'($signed(a)) * longint'($signed(K_TB)));
        r2 = ref_red(longint'($signed(b)) * longint'($signed(c)));
        r3 = ref_red(longint'($signed(r1[31:0])) * longint'($signed(r2[31:0])));
        return {r1[32] | r2[32] | r3[32], r3[31:0]};
    endfunction

    function automatic logic [31:0] rnd();
        logic [31:0] v;
        v = $urandom;
        if ($urandom_range(0, 3) == 0)
            return v;
        return {{13{v[18]}}, v[18:0]};
    endfunction

    // Monitor: samples mid-cycle what the next rising edge will accept or transfer.
    logic        prev_stall = 1'b0;
    logic [32:0] prev_out;
    always @(negedge clk) begin
        logic [63:0] bc;
        if (rst) begin
            aq.delete();
            bcq.delete();
            sb.delete();
            prev_stall = 1'b0;
            n_exp = 0;
            n_out = 0;
        end else begin
            if (prev_stall) begin
                check("hold_vld", {32'b0, out_vld}, 33'd1);
                check("hold_data", {out_ovf, out_data}, prev_out);
            end
            if (out_vld && out_rdy) begin
                n_out++;
                if (sb.size() == 0)
                    check("spurious_out", {32'b0, out_vld}, 33'd0);
                else
                    check("result", {out_ovf, out_data}, sb.pop_front());
            end
            prev_stall = out_vld && !out_rdy;
            prev_out   = {out_ovf, out_data};
            if (a_vld && a_rdy)
                aq.push_back(a_data);
            if (bc_vld && bc_rdy)
                bcq.push_back({bc_b, bc_c});
            while (aq.size() > 0 && bcq.size() > 0) begin
                bc = bcq.pop_front();
                sb.push_back(ref_term(aq.pop_front(), bc[63:32], bc[31:0]));
                n_exp++;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_pair(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        a_data = a;
        bc_b   = b;
        bc_c   = c;
        a_vld  = 1'b1;
        bc_vld = 1'b1;
        step();
        a_vld  = 1'b0;
        bc_vld = 1'b0;
    endtask

    // Called just after an accept edge; n = cycles from the accept cycle to out_vld.
    task automatic wait_out(output int n);
        n = 1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (out_vld)
                return;
            n++;
        end
    endtask

    initial begin
        int n;
        int acc;
        int na;
        int nb;
        logic acc_a;
        logic acc_b;

        rst = 1'b1;
        a_data = '0;
        a_vld = 1'b0;
        bc_b = '0;
        bc_c = '0;
        bc_vld = 1'b0;
        out_rdy = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        @(negedge clk);
        check("rst_out_vld", {32'b0, out_vld}, 33'd0);
        check("rst_out_data", {1'b0, out_data}, 33'd0);
        check("rst_out_ovf", {32'b0, out_ovf}, 33'd0);
        check("rst_a_rdy", {32'b0, a_rdy}, 33'd1);
        check("rst_bc_rdy", {32'b0, bc_rdy}, 33'd1);

        // basic product: 1.5 * -2.0 * (2.0 * 0.25) = -1.5
        push_pair(32'h00018000, 32'h00020000, 32'h00004000);
        wait_out(n);
        check("basic_latency", 33'(n), 33'd3);
        check("basic_value", {out_ovf, out_data}, {1'b0, 32'hFFFE8000});
        repeat (4) step();

        // skewed arrival: A at t, B/C at t+5
        a_data = 32'h00018000;
        a_vld  = 1'b1;
        step();
        a_vld = 1'b0;
        repeat (4) step();
        bc_b   = 32'h00020000;
        bc_c   = 32'h00004000;
        bc_vld = 1'b1;
        step();
        bc_vld = 1'b0;
        wait_out(n);
        check("skew_latency", 33'(n), 33'd3);
        check("skew_value", {out_ovf, out_data}, {1'b0, 32'hFFFE8000});
        @(negedge clk);
        check("skew_single", {32'b0, out_vld}, 33'd0);
        step();

        // fill A, then stall output while B/C arrives
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            a_data = 32'h00010000 * (i + 1);
            a_vld  = 1'b1;
            if (a_rdy)
                acc++;
            step();
        end
        a_vld = 1'b0;
        check("fill_accepted", 33'(acc), 33'd4);
        check("fill_a_rdy_low", {32'b0, a_rdy}, 33'd0);
        out_rdy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bc_b   = 32'h00008000 * (i + 1);
            bc_c   = 32'hFFFF0000;
            bc_vld = 1'b1;
            step();
        end
        bc_vld = 1'b0;
        repeat (6) step();
        check("stall_vld", {32'b0, out_vld}, 33'd1);
        out_rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("drain_consecutive", {32'b0, out_vld}, 33'd1);
        end
        @(negedge clk);
        check("drain_done", {32'b0, out_vld}, 33'd0);
        check("drain_a_rdy", {32'b0, a_rdy}, 33'd1);
        step();

        // overflow on a*K
        push_pair(32'h7FFF0000, 32'h00010000, 32'h00010000);
        wait_out(n);
        check("ovf_latency", 33'(n), 33'd3);
`ifdef PIMT_SAT_EN
        check("ovf_value", {out_ovf, out_data}, {1'b1, 32'h80000000});
`else
        check("ovf_value", {out_ovf, out_data}, {1'b1, 32'h00020000});
`endif
        repeat (3) step();

        // reset mid-flight: three pairs, rst during the third
        a_data = 32'h00018000;
        bc_b   = 32'h00020000;
        bc_c   = 32'h00004000;
        a_vld  = 1'b1;
        bc_vld = 1'b1;
        step();
        step();
        rst = 1'b1;
        step();
        rst    = 1'b0;
        a_vld  = 1'b0;
        bc_vld = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("post_rst_no_vld", {32'b0, out_vld}, 33'd0);
        end
        check("post_rst_a_rdy", {32'b0, a_rdy}, 33'd1);
        check("post_rst_bc_rdy", {32'b0, bc_rdy}, 33'd1);
        push_pair(32'h00018000, 32'h00020000, 32'h00004000);
        wait_out(n);
        check("post_rst_latency", 33'(n), 33'd3);
        check("post_rst_value", {out_ovf, out_data}, {1'b0, 32'hFFFE8000});
        repeat (3) step();

        // random stress
        na = 0;
        nb = 0;
        for (int cyc = 0; cyc < 60000 && (na < N || nb < N); cyc++) begin
            a_vld = (na < N) && ($urandom_range(0, 9) < 7);
            a_data = rnd();
            bc_vld = (nb < N) && ($urandom_range(0, 9) < 7);
            bc_b = rnd();
            bc_c = rnd();
            out_rdy = ($urandom_range(0, 3) != 0);
            acc_a = a_vld && a_rdy;
            acc_b = bc_vld && bc_rdy;
            step();
            if (acc_a)
                na++;
            if (acc_b)
                nb++;
        end
        a_vld = 1'b0;
        bc_vld = 1'b0;
        out_rdy = 1'b1;
        check("stress_sent", 33'(na + nb), 33'(2 * N));
        for (int i = 0; i < 200 && sb.size() > 0; i++)
            @(negedge clk);
        repeat (4) @(negedge clk);
        check("stress_drain", 33'(sb.size()), 33'd0);
        check("stress_count", 33'(n_out), 33'(n_exp));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
